vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Generates the VGA raster: pixel-rate tick, horizontal/vertical scan counters, hsync/vsync pulses, and the video_on / pix_x / pix_y signals.
- Its outputs feed the graphics generators (pong graphics, text overlays) and the board VGA pins.
- It is the producing end of the pix_x/pix_y/video_on interface that the graphics blocks consume.

Parameters:
- PIX_DIV, 2, system clocks per pixel (50 MHz clk -> 25 MHz pixel); legal range 1..16.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, vertical back porch in lines.
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses are driven low; 0 = driven high.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- video_on  out  1  high while the current pixel is inside the visible area
- p_tick  out  1  one-clk pulse per pixel period
- pix_x  out  10  current horizontal count, 0..H_TOTAL-1
- pix_y  out  10  current vertical count, 0..V_TOTAL-1
- line_tick  out  1  one-clk pulse on the p_tick that wraps pix_x to 0
- frame_tick  out  1  one-clk pulse at the start of vertical blanking

Behaviour:
- Reset and clocking: reset is asynchronous and active-high; clk is the clock.
- Derived constants:
  - H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
  - Both totals must be <= 1024. Violations are caught by an elaboration-time check.
- Pixel divider:
  - div_cnt counts 0..PIX_DIV-1 and wraps.
  - p_tick = (div_cnt == PIX_DIV-1), combinational from the register, so it is exactly one clk wide every PIX_DIV clks.
  - With PIX_DIV=1, p_tick is constantly 1.
- Horizontal counter:
  - h_cnt advances only on p_tick.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - v_cnt advances only on a p_tick where h_cnt == H_TOTAL-1.
  - At V_TOTAL-1 it wraps to 0 in the same cycle h_cnt wraps.
- pix_x = h_cnt and pix_y = v_cnt, direct from the registers.
- video_on = (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY); combinational from the registered counters.
- Sync outputs:
  - hsync/vsync are registered from the next-state counters, so they change in the same clk as pix_x/pix_y.
  - hsync is active for h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656, 751].
  - vsync is active for v in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490, 491].
  - "Active" is the polarity set by SYNC_ACTIVE_LOW.
- line_tick = p_tick && (h_cnt == H_TOTAL-1); combinational.
- frame_tick = p_tick && (h_cnt == H_TOTAL-1) && (v_cnt == V_DISPLAY-1); combinational. It fires once per frame, in the clk where the counters move to (0, V_DISPLAY).
- Reset values:
  - div_cnt = 0, h_cnt = 0, v_cnt = 0.
  - hsync/vsync at their inactive level (1 when SYNC_ACTIVE_LOW=1).
  - pix_x = 0, pix_y = 0.
  - video_on = 1, because it decodes counter value (0,0).
  - p_tick = 0 when PIX_DIV > 1; line_tick = 0; frame_tick = 0.
- Reset mid-frame: all state returns to the reset values immediately (asynchronous). The first p_tick after release occurs PIX_DIV clks after the first active clk edge.
- Simultaneous wrap: on the p_tick at (H_TOTAL-1, V_TOTAL-1), both counters go to 0 in the same clk. Line and frame wrap are never split across cycles.
- Counters never stall and take no external enable. Outputs toggle only on clk edges, so they are glitch-free.

Decomposition:
- Package vga_timing_pkg holds the 640x480@60 default constants (H_*, V_*, H_TOTAL, V_TOTAL) and the pixel-coordinate width (10). Graphics blocks share these constants, e.g. MAX_X/MAX_Y.
- One sub-module, vga_pix_tick: a mod-PIX_DIV counter that produces p_tick.
- Counters, sync decode and tick decode stay in the top module.

Test Plan:
- Reset check: assert reset for 3 clks, then release. During reset: pix_x=0, pix_y=0, hsync=1, vsync=1, video_on=1, p_tick=0. After release, the first p_tick arrives at the 2nd clk.
- Line wrap: run to h=799, v=5, then apply p_tick. Next clk: pix_x=0, pix_y=6, and line_tick=1 was observed for exactly one clk beforehand.
- hsync pulse: over one line, hsync is low for exactly 96 p_ticks, starting when pix_x=656 and ending after pix_x=751. video_on is low for all pix_x >= 640.
- vsync and frame timing: vsync is low for pix_y 490..491 (1600 p_ticks). Successive frame_ticks are 840000 clks apart, and pix_y=480, pix_x=0 in the clk after each frame_tick.
- Async reset mid-frame: assert reset at pix_x=300, pix_y=200 between clk edges. Outputs return to reset values before the next edge, and counting restarts from (0,0).
- PIX_DIV=1 build: p_tick is constantly 1, a line takes 800 clks, and a frame takes 420000 clks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants and the pixel-coordinate width.
// Graphics blocks import this to size their coordinates and screen bounds.
package vga_timing_pkg;

    localparam int COORD_W   = 10;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Visible screen extent as seen by the graphics generators
    localparam int MAX_X     = H_DISPLAY;
    localparam int MAX_Y     = V_DISPLAY;

    // True when a scan coordinate lies in the inclusive range [lo, hi]
    function automatic logic in_window(input logic [COORD_W-1:0] val,
                                       input int lo, input int hi);
        return (int'(val) >= lo) && (int'(val) <= hi);
    endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate divider: a mod-PIX_DIV counter whose last count is the pixel tick.
// With PIX_DIV = 1 the counter is pinned at its last value, so the tick is always high.
module vga_pix_tick #(
    parameter int PIX_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int              DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // Count 0..PIX_DIV-1 and wrap; runs freely whenever out of reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign p_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: scan counters, registered sync pulses, visible-area flag
// and line/frame strobes. Produces the pix_x/pix_y/video_on stream for the
// graphics blocks. Syncs are registered from the next-state counters so they
// line up with pix_x/pix_y in the same clk.
module vga_sync_gen #(
    parameter int PIX_DIV         = 2,
    parameter int H_DISPLAY       = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT         = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC          = vga_timing_pkg::H_SYNC,
    parameter int H_BACK          = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY       = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT         = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC          = vga_timing_pkg::V_SYNC,
    parameter int V_BACK          = vga_timing_pkg::V_BACK,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic                               hsync,
    output logic                               vsync,
    output logic                               video_on,
    output logic                               p_tick,
    output logic [vga_timing_pkg::COORD_W-1:0] pix_x,
    output logic [vga_timing_pkg::COORD_W-1:0] pix_y,
    output logic                               line_tick,
    output logic                               frame_tick
);

    import vga_timing_pkg::*;

    localparam int H_TOT    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] V_VIS_LAST = COORD_W'(V_DISPLAY - 1);

    localparam logic SYNC_ON  = ~SYNC_ACTIVE_LOW;
    localparam logic SYNC_OFF = SYNC_ACTIVE_LOW;

    if ((H_TOT > (1 << COORD_W)) || (V_TOT > (1 << COORD_W))) begin : g_total_check
        $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the 10-bit scan counter range");
    end

    if ((PIX_DIV < 1) || (PIX_DIV > 16)) begin : g_div_check
        $error("vga_sync_gen: PIX_DIV must be within 1..16");
    end

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic [COORD_W-1:0] h_nxt;
    logic [COORD_W-1:0] v_nxt;
    logic               end_of_line;

    vga_pix_tick #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_tick (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    assign end_of_line = p_tick && (h_cnt == H_LAST);

    // Next scan position: h steps per pixel, v steps on the line wrap, both wrap together
    always_comb begin
        h_nxt = h_cnt;
        v_nxt = v_cnt;
        if (p_tick) begin
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_nxt = h_cnt + 1'b1;
            end
        end
    end

    // Scan counters and syncs; syncs decode the next position to stay aligned with pix_x/pix_y
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
            hsync <= SYNC_OFF;
            vsync <= SYNC_OFF;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            hsync <= in_window(h_nxt, HS_START, HS_END) ? SYNC_ON : SYNC_OFF;
            vsync <= in_window(v_nxt, VS_START, VS_END) ? SYNC_ON : SYNC_OFF;
        end
    end

    assign pix_x      = h_cnt;
    assign pix_y      = v_cnt;
    assign video_on   = (int'(h_cnt) < H_DISPLAY) && (int'(v_cnt) < V_DISPLAY);
    assign line_tick  = end_of_line;
    assign frame_tick = end_of_line && (v_cnt == V_VIS_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen. Three builds share clk/reset:
//   dut   - default 640x480 timing, PIX_DIV=2, active-low syncs
//   dut_s - tiny 16x12 raster (8x6 visible), PIX_DIV=3, active-high syncs, for frame-level timing
//   dut_1 - default timing, PIX_DIV=1
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    logic       hsync, vsync, video_on, p_tick, line_tick, frame_tick;
    logic [9:0] pix_x, pix_y;
    logic       s_hsync, s_vsync, s_video_on, s_p_tick, s_line_tick, s_frame_tick;
    logic [9:0] s_pix_x, s_pix_y;
    logic       o_hsync, o_vsync, o_video_on, o_p_tick, o_line_tick, o_frame_tick;
    logic [9:0] o_pix_x, o_pix_y;

    int checks   = 0;
    int failures = 0;

    vga_sync_gen dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .p_tick(p_tick), .pix_x(pix_x), .pix_y(pix_y), .line_tick(line_tick),
        .frame_tick(frame_tick)
    );

    vga_sync_gen #(
        .PIX_DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SYNC_ACTIVE_LOW(1'b0)
    ) dut_s (
        .clk(clk), .reset(reset), .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on),
        .p_tick(s_p_tick), .pix_x(s_pix_x), .pix_y(s_pix_y), .line_tick(s_line_tick),
        .frame_tick(s_frame_tick)
    );

    vga_sync_gen #(
        .PIX_DIV(1)
    ) dut_1 (
        .clk(clk), .reset(reset), .hsync(o_hsync), .vsync(o_vsync), .video_on(o_video_on),
        .p_tick(o_p_tick), .pix_x(o_pix_x), .pix_y(o_pix_y), .line_tick(o_line_tick),
        .frame_tick(o_frame_tick)
    );

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (pix_x !== 10'd0)     begin failures++; $display("FAIL reset_pix_x got=%0d exp=0", pix_x); end
        checks++; if (pix_y !== 10'd0)     begin failures++; $display("FAIL reset_pix_y got=%0d exp=0", pix_y); end
        checks++; if (hsync !== 1'b1)      begin failures++; $display("FAIL reset_hsync got=%b exp=1", hsync); end
        checks++; if (vsync !== 1'b1)      begin failures++; $display("FAIL reset_vsync got=%b exp=1", vsync); end
        checks++; if (video_on !== 1'b1)   begin failures++; $display("FAIL reset_video_on got=%b exp=1", video_on); end
        checks++; if (p_tick !== 1'b0)     begin failures++; $display("FAIL reset_p_tick got=%b exp=0", p_tick); end
        checks++; if (line_tick !== 1'b0)  begin failures++; $display("FAIL reset_line_tick got=%b exp=0", line_tick); end
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_frame_tick got=%b exp=0", frame_tick); end
        checks++; if (s_hsync !== 1'b0 || s_vsync !== 1'b0) begin failures++; $display("FAIL reset_hi_pol_sync got=%b%b exp=00", s_hsync, s_vsync); end
        checks++; if (o_p_tick !== 1'b1)   begin failures++; $display("FAIL reset_div1_p_tick got=%b exp=1", o_p_tick); end
        reset = 1'b0;
        #1;
        checks++; if (p_tick !== 1'b0) begin failures++; $display("FAIL release_p_tick got=%b exp=0", p_tick); end
        @(negedge clk);
        checks++; if (p_tick !== 1'b1 || pix_x !== 10'd0) begin failures++; $display("FAIL first_p_tick got p_tick=%b x=%0d exp p_tick=1 x=0", p_tick, pix_x); end
        @(negedge clk);
        checks++; if (p_tick !== 1'b0 || pix_x !== 10'd1) begin failures++; $display("FAIL first_step got p_tick=%b x=%0d exp p_tick=0 x=1", p_tick, pix_x); end
    endtask

    task automatic test_line_wrap();
        int n = 0;
        while (!(pix_x == 10'd799 && pix_y == 10'd5) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 20000) begin failures++; $display("FAIL line_wrap_timeout got=%0d cycles exp<20000", n); end
        checks++; if (line_tick !== 1'b0) begin failures++; $display("FAIL line_tick_early got=%b exp=0", line_tick); end
        @(negedge clk);
        checks++; if (p_tick !== 1'b1 || line_tick !== 1'b1) begin failures++; $display("FAIL line_tick got p_tick=%b line_tick=%b exp 1 1", p_tick, line_tick); end
        @(negedge clk);
        checks++; if (pix_x !== 10'd0 || pix_y !== 10'd6) begin failures++; $display("FAIL line_wrap_pos got=(%0d,%0d) exp=(0,6)", pix_x, pix_y); end
        checks++; if (line_tick !== 1'b0) begin failures++; $display("FAIL line_tick_late got=%b exp=0", line_tick); end
    endtask

    task automatic test_hsync();
        int pix_cnt = 0, low_cnt = 0, vid_err = 0;
        int first_low = -1, last_low = -1;
        for (int i = 0; i < 1600; i++) begin
            if (p_tick) begin
                pix_cnt++;
                if (hsync == 1'b0) begin
                    low_cnt++;
                    if (first_low < 0) first_low = int'(pix_x);
                    last_low = int'(pix_x);
                end
                if (video_on !== (pix_x < 10'd640)) vid_err++;
            end
            @(negedge clk);
        end
        checks++; if (pix_cnt != 800)   begin failures++; $display("FAIL line_p_ticks got=%0d exp=800", pix_cnt); end
        checks++; if (low_cnt != 96)    begin failures++; $display("FAIL hsync_width got=%0d exp=96", low_cnt); end
        checks++; if (first_low != 656) begin failures++; $display("FAIL hsync_start got=%0d exp=656", first_low); end
        checks++; if (last_low != 751)  begin failures++; $display("FAIL hsync_end got=%0d exp=751", last_low); end
        checks++; if (vid_err != 0)     begin failures++; $display("FAIL video_on_h got=%0d errors exp=0", vid_err); end
        checks++; if (pix_x !== 10'd0 || pix_y !== 10'd7) begin failures++; $display("FAIL next_line_pos got=(%0d,%0d) exp=(0,7)", pix_x, pix_y); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        while (!(pix_x == 10'd700 && pix_y == 10'd8) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 5000) begin failures++; $display("FAIL async_wait_timeout got=%0d cycles exp<5000", n); end
        checks++; if (hsync !== 1'b0 || video_on !== 1'b0) begin failures++; $display("FAIL pre_reset got hsync=%b video_on=%b exp 0 0", hsync, video_on); end
        #2 reset = 1'b1;
        #1;
        checks++; if (pix_x !== 10'd0 || pix_y !== 10'd0) begin failures++; $display("FAIL async_pos got=(%0d,%0d) exp=(0,0)", pix_x, pix_y); end
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1)   begin failures++; $display("FAIL async_sync got=%b%b exp=11", hsync, vsync); end
        checks++; if (video_on !== 1'b1 || p_tick !== 1'b0) begin failures++; $display("FAIL async_flags got video_on=%b p_tick=%b exp 1 0", video_on, p_tick); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (pix_x !== 10'd1 || pix_y !== 10'd0) begin failures++; $display("FAIL restart_pos got=(%0d,%0d) exp=(1,0)", pix_x, pix_y); end
    endtask

    task automatic test_pix_div1();
        int tick_err = 0, step_err = 0, n = 0;
        logic [9:0] prev;
        prev = o_pix_x;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_p_tick !== 1'b1) tick_err++;
            if (o_pix_x !== prev + 10'd1) step_err++;
            prev = o_pix_x;
        end
        checks++; if (tick_err != 0) begin failures++; $display("FAIL div1_p_tick got=%0d low cycles exp=0", tick_err); end
        checks++; if (step_err != 0) begin failures++; $display("FAIL div1_step got=%0d bad steps exp=0", step_err); end
        while (!o_line_tick && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 1000) begin failures++; $display("FAIL div1_line_timeout got=%0d exp<1000", n); end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                checks++; if (o_pix_x !== 10'd0) begin failures++; $display("FAIL div1_wrap got=%0d exp=0", o_pix_x); end
            end
        end while (!o_line_tick && n < 1000);
        checks++; if (n != 800) begin failures++; $display("FAIL div1_line_len got=%0d exp=800", n); end
    endtask

    task automatic test_vsync_frame();
        int n = 0, pix = 0, vs_cnt = 0, hs_cnt = 0, vis = 0;
        int vs_min = 1000, vs_max = -1;
        while (!s_frame_tick && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 2000) begin failures++; $display("FAIL frame_wait_timeout got=%0d exp<2000", n); end
        checks++; if (s_pix_x !== 10'd15 || s_pix_y !== 10'd5) begin failures++; $display("FAIL frame_tick_pos got=(%0d,%0d) exp=(15,5)", s_pix_x, s_pix_y); end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                checks++; if (s_pix_x !== 10'd0 || s_pix_y !== 10'd6) begin failures++; $display("FAIL after_frame_pos got=(%0d,%0d) exp=(0,6)", s_pix_x, s_pix_y); end
            end
            if (s_p_tick) begin
                pix++;
                if (s_video_on) vis++;
                if (s_hsync) hs_cnt++;
                if (s_vsync) begin
                    vs_cnt++;
                    if (int'(s_pix_y) < vs_min) vs_min = int'(s_pix_y);
                    if (int'(s_pix_y) > vs_max) vs_max = int'(s_pix_y);
                end
            end
        end while (!s_frame_tick && n < 1200);
        checks++; if (n != 576)    begin failures++; $display("FAIL frame_period got=%0d exp=576", n); end
        checks++; if (pix != 192)  begin failures++; $display("FAIL frame_pixels got=%0d exp=192", pix); end
        checks++; if (vis != 48)   begin failures++; $display("FAIL frame_visible got=%0d exp=48", vis); end
        checks++; if (hs_cnt != 36) begin failures++; $display("FAIL frame_hsync got=%0d exp=36", hs_cnt); end
        checks++; if (vs_cnt != 32) begin failures++; $display("FAIL vsync_width got=%0d exp=32", vs_cnt); end
        checks++; if (vs_min != 8 || vs_max != 9) begin failures++; $display("FAIL vsync_lines got=%0d..%0d exp=8..9", vs_min, vs_max); end
    endtask

    task automatic test_simul_wrap();
        int n = 0;
        while (!(s_pix_x == 10'd15 && s_pix_y == 10'd11 && s_p_tick) && n < 1200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 1200) begin failures++; $display("FAIL wrap_wait_timeout got=%0d exp<1200", n); end
        checks++; if (s_line_tick !== 1'b1 || s_frame_tick !== 1'b0) begin failures++; $display("FAIL wrap_ticks got line=%b frame=%b exp 1 0", s_line_tick, s_frame_tick); end
        checks++; if (s_vsync !== 1'b0) begin failures++; $display("FAIL wrap_vsync_pre got=%b exp=0", s_vsync); end
        @(negedge clk);
        checks++; if (s_pix_x !== 10'd0 || s_pix_y !== 10'd0) begin failures++; $display("FAIL wrap_pos got=(%0d,%0d) exp=(0,0)", s_pix_x, s_pix_y); end
        checks++; if (s_video_on !== 1'b1) begin failures++; $display("FAIL wrap_video_on got=%b exp=1", s_video_on); end
    endtask

    initial begin
        test_reset();
        test_line_wrap();
        test_hsync();
        test_async_reset();
        test_pix_div1();
        test_vsync_frame();
        test_simul_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
